cmd_dispatch_queue: RTL and testbench
=====================================

Name: cmd_dispatch_queue

Overview:
- Host-facing command queue placed directly upstream of control_unit.
- Buffers up to DEPTH 64-bit GEMM commands from the host and issues them one at a time over control_unit's cmd_valid/cmd_data/cmd_ready handshake.
- Keeps exactly one command in flight and waits for done_irq before issuing the next.
- Keeps issue/completion counters and raises one sticky batch-complete interrupt when the queue drains.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- CMD_WIDTH, 64, command word width.
- ADDR_WIDTH, 10, unified-buffer address width used by the command fields.
- SYSTOLIC_ARRAY_WIDTH, 16, array dimension W; used for length checks.
- CNT_WIDTH, 16, width of the issued/completed counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- host_cmd_valid  in  1  host presents a command.
- host_cmd_data  in  CMD_WIDTH  command word, command_t layout.
- host_cmd_ready  out  1  queue can accept a command.
- cu_cmd_valid  out  1  command offered to control_unit.
- cu_cmd_data  out  CMD_WIDTH  offered command.
- cu_cmd_ready  in  1  control_unit accepts.
- cu_done_irq  in  1  one-cycle completion pulse from control_unit.
- queue_level  out  $clog2(DEPTH)+1  number of entries held.
- cmds_issued  out  CNT_WIDTH  commands accepted by control_unit.
- cmds_completed  out  CNT_WIDTH  done pulses received.
- batch_irq  out  1  sticky batch-complete interrupt.
- irq_clear  in  1  clears batch_irq.
- idle  out  1  queue empty and state IDLE.

Behaviour:
- Reset: all outputs 0 except idle=1 and host_cmd_ready=1. Pointers, counters and FSM are cleared; queued commands are discarded.
- Reset mid-operation: any in-flight command is abandoned. A late cu_done_irq after reset is counted in cmds_completed.
- Command layout, LSB first:
  - len_m [7:0]
  - len_k [15:8]
  - len_n [23:16]
  - addr_a [33:24]
  - addr_b [43:34]
  - addr_c [53:44]
  - addr_d [63:54]
- Push:
  - Occurs when host_cmd_valid && host_cmd_ready.
  - host_cmd_ready = (queue_level < DEPTH), decoded from registered state only.
  - When the queue is full, a push is refused even if a pop happens in the same cycle.
- Queue storage: circular buffer, write/read pointers wrap modulo DEPTH. Simultaneous push and pop keeps queue_level unchanged.
- FSM states and transitions:
  - IDLE → ISSUE when the queue is non-empty. The head is registered into cu_cmd_data and cu_cmd_valid goes high on the next edge.
  - A push into an empty queue at edge N gives cu_cmd_valid=1 after edge N+1.
  - ISSUE: cu_cmd_valid and cu_cmd_data are held stable until cu_cmd_ready. On handshake: pop the head, increment cmds_issued, drop cu_cmd_valid, go to WAIT_DONE.
  - WAIT_DONE: on cu_done_irq, increment cmds_completed and go to IDLE.
  - A cu_done_irq outside WAIT_DONE is counted but causes no state change.
- Back-to-back issue: the earliest next cu_cmd_valid comes 2 cycles after the done pulse (IDLE, then load).
- Counters wrap modulo 2^CNT_WIDTH with no saturation.
- batch_irq:
  - Set on the cycle WAIT_DONE exits with the queue empty and no push in that cycle.
  - Cleared by irq_clear.
  - If set and clear occur in the same cycle, set wins.
- idle = (queue_level==0) && state==IDLE.

Optional Feature:
- Macro: CMD_CHECK_EN.
- With the macro defined:
  - At ISSUE load, a command is illegal if len_m, len_k or len_n is 0 or greater than SYSTOLIC_ARRAY_WIDTH.
  - An illegal command is popped without being offered: cu_cmd_valid stays 0 and cmds_issued is not incremented.
  - Extra port err_count (out, CNT_WIDTH) increments per dropped command.
  - The FSM returns to IDLE.
  - A drop that empties the queue after at least one issue since the last irq also sets batch_irq.
- Without the macro: no checks, no err_count port, every command is issued.

Decomposition:
- Shared package tpu_cmd_pkg holds:
  - command_t (packed struct, field order above, addr_d MSB), also used by control_unit.
  - Field width constants LEN_WIDTH=8 and CMD_WIDTH=64.
  - The dispatch state enum.
- Natural sub-module cmd_fifo: parameterised circular buffer with push/pop/full/empty/level.
- cmd_dispatch_queue holds the FSM, counters and irq.

Test Plan:
- Reset, then one push of a command with K=8, N=8, A=0x100, B=0x200, C=0x300, D=0x400:
  - cu_cmd_valid=1 two edges after the push, data equal to the push.
  - cu_cmd_ready held 0 for 3 cycles → data stable.
  - Ready → cmds_issued=1.
  - done pulse → cmds_completed=1, batch_irq=1, idle=1.
- Push 4 commands with cu_cmd_ready=0: queue_level=4 and host_cmd_ready=0; a 5th push is refused. After the first pop, host_cmd_ready=1 again.
- Push 6 commands interleaved with completions: issue order equals push order across pointer wrap; cmds_issued=6; batch_irq set only once, after the 6th done.
- batch_irq=1 with irq_clear asserted in the same cycle a new batch-end set occurs → batch_irq stays 1. Clear alone → 0.
- Assert rst (low) while in WAIT_DONE with 2 queued: queue_level=0, counters 0, cu_cmd_valid=0 immediately (asynchronous); the next push issues normally.
- CMD_CHECK_EN: push K=0, then K=17, then a valid command → err_count=2, only the valid command is offered, cmds_issued=1.

Source files
------------

// File: rtl/tpu_cmd_pkg.sv
// Shared GEMM command definitions: the command word layout, its field widths
// and the dispatch state encoding used by cmd_dispatch_queue and control_unit.
package tpu_cmd_pkg;

    localparam int LEN_WIDTH        = 8;
    localparam int CMD_WIDTH        = 64;
    localparam int ADDR_FIELD_WIDTH = 10;

    // Field order is MSB first, so len_m lands in bits [7:0].
    typedef struct packed {
        logic [ADDR_FIELD_WIDTH-1:0] addr_d;
        logic [ADDR_FIELD_WIDTH-1:0] addr_c;
        logic [ADDR_FIELD_WIDTH-1:0] addr_b;
        logic [ADDR_FIELD_WIDTH-1:0] addr_a;
        logic [LEN_WIDTH-1:0]        len_n;
        logic [LEN_WIDTH-1:0]        len_k;
        logic [LEN_WIDTH-1:0]        len_m;
    } command_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } dispatch_state_t;

    function automatic logic len_in_range(input logic [LEN_WIDTH-1:0] len, input int max_len);
        return (len != '0) && (int'({24'd0, len}) <= max_len);
    endfunction

    function automatic logic cmd_lens_legal(input command_t cmd, input int max_len);
        return len_in_range(cmd.len_m, max_len) &&
               len_in_range(cmd.len_k, max_len) &&
               len_in_range(cmd.len_n, max_len);
    endfunction

endpackage

// File: rtl/cmd_dispatch_queue_if.sv
// Host-side and control_unit-side command handshakes of the dispatch queue.
// slave = the queue itself, master = whoever drives host commands and cu responses.
interface cmd_dispatch_queue_if #(
    parameter int CMD_WIDTH = 64
);
    logic                 host_cmd_valid;
    logic [CMD_WIDTH-1:0] host_cmd_data;
    logic                 host_cmd_ready;
    logic                 cu_cmd_valid;
    logic [CMD_WIDTH-1:0] cu_cmd_data;
    logic                 cu_cmd_ready;
    logic                 cu_done_irq;

    modport slave (
        input  host_cmd_valid, host_cmd_data, cu_cmd_ready, cu_done_irq,
        output host_cmd_ready, cu_cmd_valid, cu_cmd_data
    );

    modport master (
        output host_cmd_valid, host_cmd_data, cu_cmd_ready, cu_done_irq,
        input  host_cmd_ready, cu_cmd_valid, cu_cmd_data
    );
endinterface

// File: rtl/cmd_fifo.sv
// Circular command buffer with registered level; a push is refused while full,
// even when a pop happens in the same cycle.
module cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/cmd_dispatch_queue.sv
// Queues host GEMM commands and issues them to control_unit one at a time.
// Build macro CMD_CHECK_EN: drop commands with out-of-range lengths, count them on err_count.
module cmd_dispatch_queue
    import tpu_cmd_pkg::*;
#(
    parameter int DEPTH                = 4,
    parameter int CMD_WIDTH            = 64,
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    cmd_dispatch_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0]   queue_level,
    output logic [CNT_WIDTH-1:0]     cmds_issued,
    output logic [CNT_WIDTH-1:0]     cmds_completed,
    output logic                     batch_irq,
    input  logic                     irq_clear,
`ifdef CMD_CHECK_EN
    output logic                     idle,
    output logic [CNT_WIDTH-1:0]     err_count
`else
    output logic                     idle
`endif
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CMD_WIDTH != $bits(command_t) ||
        ADDR_WIDTH != ADDR_FIELD_WIDTH || SYSTOLIC_ARRAY_WIDTH < 1 ||
        SYSTOLIC_ARRAY_WIDTH >= (1 << LEN_WIDTH)) begin : g_bad_cfg
        $error("cmd_dispatch_queue: unsupported parameter combination");
    end

    dispatch_state_t      r_state;
    logic                 r_cu_valid;
    logic [CMD_WIDTH-1:0] r_cu_data;
    logic [CNT_WIDTH-1:0] r_issued;
    logic [CNT_WIDTH-1:0] r_completed;
    logic                 r_batch_irq;

    logic [CMD_WIDTH-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [LVL_W-1:0]     w_level;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_handshake;
    logic                 w_done_exit;
    logic                 w_drop;
    logic                 w_batch_set;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.host_cmd_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign w_push      = bus.host_cmd_valid && !w_full;
    assign w_handshake = (r_state == ST_ISSUE) && bus.cu_cmd_ready;
    assign w_done_exit = (r_state == ST_WAIT_DONE) && bus.cu_done_irq;
    // The offered command stays in the queue until control_unit takes it.
    assign w_pop       = w_handshake || w_drop;

`ifdef CMD_CHECK_EN
    command_t             w_head_cmd;
    logic                 r_since_irq;
    logic [CNT_WIDTH-1:0] r_err;

    assign w_head_cmd  = w_head;
    assign w_drop      = (r_state == ST_IDLE) && !w_empty &&
                         !cmd_lens_legal(w_head_cmd, SYSTOLIC_ARRAY_WIDTH);
    assign w_batch_set = (w_done_exit && w_empty && !w_push) ||
                         (w_drop && (w_level == LVL_W'(1)) && !w_push && r_since_irq);
    assign err_count   = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err       <= '0;
            r_since_irq <= 1'b0;
        end else begin
            if (w_drop) begin
                r_err <= r_err + CNT_WIDTH'(1);
            end
            if (w_batch_set) begin
                r_since_irq <= 1'b0;
            end else if (w_handshake) begin
                r_since_irq <= 1'b1;
            end
        end
    end
`else
    assign w_drop      = 1'b0;
    assign w_batch_set = w_done_exit && w_empty && !w_push;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cu_valid <= 1'b0;
            r_cu_data  <= '0;
            r_issued   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && !w_drop) begin
                        r_cu_data  <= w_head;
                        r_cu_valid <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.cu_cmd_ready) begin
                        r_cu_valid <= 1'b0;
                        r_issued   <= r_issued + CNT_WIDTH'(1);
                        r_state    <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.cu_done_irq) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_cu_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Done pulses are counted in every state, including stray ones after a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_completed <= '0;
            r_batch_irq <= 1'b0;
        end else begin
            if (bus.cu_done_irq) begin
                r_completed <= r_completed + CNT_WIDTH'(1);
            end
            if (w_batch_set) begin
                r_batch_irq <= 1'b1;
            end else if (irq_clear) begin
                r_batch_irq <= 1'b0;
            end
        end
    end

    assign bus.host_cmd_ready = !w_full;
    assign bus.cu_cmd_valid   = r_cu_valid;
    assign bus.cu_cmd_data    = r_cu_data;
    assign queue_level        = w_level;
    assign cmds_issued        = r_issued;
    assign cmds_completed     = r_completed;
    assign batch_irq          = r_batch_irq;
    assign idle               = w_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_cmd_dispatch_queue.sv
// Bench for cmd_dispatch_queue: directed and random traffic compared every cycle
// against a transaction-level model (command queue plus offer/wait flags).
module tb_cmd_dispatch_queue;
    import tpu_cmd_pkg::*;

    localparam int DEPTH = 4;
    localparam int SAW   = 16;

    logic        clk;
    logic        rst;
    logic        irq_clear;
    logic [2:0]  queue_level;
    logic [15:0] cmds_issued;
    logic [15:0] cmds_completed;
    logic        batch_irq;
    logic        idle;
`ifdef CMD_CHECK_EN
    logic [15:0] err_count;
`endif

    cmd_dispatch_queue_if #(.CMD_WIDTH(64)) bus ();

    cmd_dispatch_queue #(
        .DEPTH(DEPTH), .CMD_WIDTH(64), .ADDR_WIDTH(10),
        .SYSTOLIC_ARRAY_WIDTH(SAW), .CNT_WIDTH(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .queue_level    (queue_level),
        .cmds_issued    (cmds_issued),
        .cmds_completed (cmds_completed),
        .batch_irq      (batch_irq),
        .irq_clear      (irq_clear),
`ifdef CMD_CHECK_EN
        .idle           (idle),
        .err_count      (err_count)
`else
        .idle           (idle)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int total = 0;
    int bad   = 0;

    // Reference model: pending commands in push order plus the dispatch situation.
    logic [63:0] exp_q[$];
    bit          m_offer, m_wait, m_batch, m_since, m_push_ok;
    logic [15:0] m_issued, m_completed, m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_cmd(input int m, input int k, input int n,
                                           input logic [9:0] a, input logic [9:0] b,
                                           input logic [9:0] c, input logic [9:0] d);
        logic [63:0] w;
        w = {d, c, b, a, 8'(n), 8'(k), 8'(m)};
        return w;
    endfunction

    function automatic logic [63:0] rand_cmd();
        return mk_cmd(int'($urandom_range(1, SAW)), int'($urandom_range(1, SAW)),
                      int'($urandom_range(1, SAW)), 10'($urandom), 10'($urandom),
                      10'($urandom), 10'($urandom));
    endfunction

    function automatic bit legal(input logic [63:0] w);
        int m, k, n;
        m = int'(w[7:0]);
        k = int'(w[15:8]);
        n = int'(w[23:16]);
        return (m >= 1 && m <= SAW) && (k >= 1 && k <= SAW) && (n >= 1 && n <= SAW);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_offer = 0; m_wait = 0; m_batch = 0; m_since = 0; m_push_ok = 0;
        m_issued = '0; m_completed = '0; m_err = '0;
    endtask

    task automatic model_update(input bit pv, input logic [63:0] pd, input bit rdy,
                                input bit done, input bit clr);
        int sz;
        bit push_ok, hs, ex, set_b;
        sz      = exp_q.size();
        push_ok = pv && (sz < DEPTH);
        hs      = m_offer && rdy;
        ex      = m_wait && done;
        set_b   = ex && (sz == 0) && !push_ok;
        if (done) m_completed++;
        if (hs) begin
            void'(exp_q.pop_front());
            m_issued++;
            m_offer = 0;
            m_wait  = 1;
            m_since = 1;
        end else if (ex) begin
            m_wait = 0;
        end else if (!m_offer && !m_wait && sz > 0) begin
`ifdef CMD_CHECK_EN
            if (!legal(exp_q[0])) begin
                void'(exp_q.pop_front());
                m_err++;
                if (sz == 1 && !push_ok && m_since) set_b = 1;
            end else begin
                m_offer = 1;
            end
`else
            m_offer = 1;
`endif
        end
        if (set_b) m_since = 0;
        if (push_ok) exp_q.push_back(pd);
        m_batch   = set_b ? 1'b1 : (clr ? 1'b0 : m_batch);
        m_push_ok = push_ok;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/level"}, 64'(queue_level), 64'(exp_q.size()));
        chk({tag, "/host_ready"}, 64'(bus.host_cmd_ready), 64'(exp_q.size() < DEPTH));
        chk({tag, "/cu_valid"}, 64'(bus.cu_cmd_valid), 64'(m_offer));
        if (m_offer) chk({tag, "/cu_data"}, bus.cu_cmd_data, exp_q[0]);
        chk({tag, "/issued"}, 64'(cmds_issued), 64'(m_issued));
        chk({tag, "/completed"}, 64'(cmds_completed), 64'(m_completed));
        chk({tag, "/batch_irq"}, 64'(batch_irq), 64'(m_batch));
        chk({tag, "/idle"}, 64'(idle), 64'(exp_q.size() == 0 && !m_offer && !m_wait));
`ifdef CMD_CHECK_EN
        chk({tag, "/err_count"}, 64'(err_count), 64'(m_err));
`endif
    endtask

    task automatic cyc(input bit pv, input logic [63:0] pd, input bit rdy, input bit done,
                       input bit clr, input string tag);
        bus.host_cmd_valid = pv;
        bus.host_cmd_data  = pd;
        bus.cu_cmd_ready   = rdy;
        bus.cu_done_irq    = done;
        irq_clear          = clr;
        @(posedge clk);
        model_update(pv, pd, rdy, done, clr);
        #1;
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !m_offer && !m_wait) break;
            cyc(1'b0, 64'h0, 1'b1, m_wait, 1'b0, tag);
        end
        chk({tag, "/drained"}, 64'(idle), 64'h1);
    endtask

    initial begin
        logic [63:0] c1, c;
        int          pushed, rises;
        bit          prev_b;
        logic [15:0] base;

        rst = 1'b0;
        irq_clear = 1'b0;
        bus.host_cmd_valid = 1'b0;
        bus.host_cmd_data  = '0;
        bus.cu_cmd_ready   = 1'b0;
        bus.cu_done_irq    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_all("reset");
        chk("reset/cu_data_zero", bus.cu_cmd_data, 64'h0);
        rst = 1'b1;

        // Single command through the whole handshake.
        c1 = mk_cmd(8, 8, 8, 10'h100, 10'h200, 10'h300, 10'h400);
        cyc(1, c1, 0, 0, 0, "t1_push");
        chk("t1_not_yet_valid", 64'(bus.cu_cmd_valid), 64'h0);
        cyc(0, 64'h0, 0, 0, 0, "t1_load");
        chk("t1_valid", 64'(bus.cu_cmd_valid), 64'h1);
        chk("t1_data", bus.cu_cmd_data, c1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 64'h0, 0, 0, 0, "t1_hold");
            chk("t1_data_stable", bus.cu_cmd_data, c1);
        end
        cyc(0, 64'h0, 1, 0, 0, "t1_accept");
        chk("t1_issued", 64'(cmds_issued), 64'h1);
        cyc(0, 64'h0, 0, 1, 0, "t1_done");
        chk("t1_completed", 64'(cmds_completed), 64'h1);
        chk("t1_batch", 64'(batch_irq), 64'h1);
        chk("t1_idle", 64'(idle), 64'h1);
        cyc(0, 64'h0, 0, 0, 1, "t1_clear");

        // Fill the queue while control_unit stalls.
        for (int i = 0; i < 4; i++) cyc(1, rand_cmd(), 0, 0, 0, "fill");
        chk("fill_level", 64'(queue_level), 64'h4);
        chk("fill_host_ready", 64'(bus.host_cmd_ready), 64'h0);
        cyc(1, rand_cmd(), 0, 0, 0, "fill_refused");
        chk("fill_refused_level", 64'(queue_level), 64'h4);
        cyc(0, 64'h0, 1, 0, 0, "fill_pop");
        chk("fill_ready_again", 64'(bus.host_cmd_ready), 64'h1);
        drain("fill_drain");
        cyc(0, 64'h0, 0, 0, 1, "fill_clear");

        // Six commands with completions interleaved; queue never idles mid-batch.
        base = cmds_issued;
        pushed = 0; rises = 0; prev_b = batch_irq;
        for (int i = 0; i < 300; i++) begin
            if (pushed == 6 && exp_q.size() == 0 && !m_offer && !m_wait) break;
            cyc(pushed < 6, rand_cmd(), 1,
                m_wait && (exp_q.size() > 0 || pushed == 6) && ($urandom_range(0, 1) == 1),
                0, "seq6");
            if (m_push_ok) pushed++;
            if (!prev_b && batch_irq) rises++;
            prev_b = batch_irq;
        end
        chk("seq6_issued", 64'(cmds_issued), 64'(base + 16'd6));
        chk("seq6_batch_once", 64'(rises), 64'h1);

        // Set and clear in the same cycle: set wins; clear alone then drops it.
        cyc(1, rand_cmd(), 0, 0, 0, "setclr_push");
        cyc(0, 64'h0, 0, 0, 0, "setclr_load");
        cyc(0, 64'h0, 1, 0, 0, "setclr_accept");
        cyc(0, 64'h0, 0, 1, 1, "setclr_both");
        chk("setclr_set_wins", 64'(batch_irq), 64'h1);
        cyc(0, 64'h0, 0, 0, 1, "setclr_clear");
        chk("setclr_cleared", 64'(batch_irq), 64'h0);

        // Random traffic including stray done pulses and clears.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1) == 1, rand_cmd(), $urandom_range(0, 1) == 1,
                m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0),
                $urandom_range(0, 9) == 0, "rand");
        end
        drain("rand_drain");

        // Asynchronous reset while waiting for done with two commands queued.
        cyc(1, rand_cmd(), 0, 0, 0, "rst_push1");
        cyc(1, rand_cmd(), 0, 0, 0, "rst_push2");
        cyc(1, rand_cmd(), 1, 0, 0, "rst_push3");
        chk("rst_pre_level", 64'(queue_level), 64'h2);
        bus.host_cmd_valid = 1'b0;
        bus.cu_cmd_ready   = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_async_level", 64'(queue_level), 64'h0);
        chk("rst_async_valid", 64'(bus.cu_cmd_valid), 64'h0);
        chk("rst_async_issued", 64'(cmds_issued), 64'h0);
        chk("rst_async_completed", 64'(cmds_completed), 64'h0);
        check_all("rst_async");
        #2;
        rst = 1'b1;
        cyc(0, 64'h0, 0, 1, 0, "rst_late_done");
        chk("rst_late_done_counted", 64'(cmds_completed), 64'h1);
        c = rand_cmd();
        cyc(1, c, 0, 0, 0, "rst_after_push");
        cyc(0, 64'h0, 0, 0, 0, "rst_after_load");
        chk("rst_after_data", bus.cu_cmd_data, c);
        drain("rst_after_drain");

`ifdef CMD_CHECK_EN
        // Illegal lengths are dropped without being offered.
        base = cmds_issued;
        cyc(1, mk_cmd(8, 0, 8, 10'h1, 10'h2, 10'h3, 10'h4), 0, 0, 0, "chk_k0");
        cyc(1, mk_cmd(8, 17, 8, 10'h5, 10'h6, 10'h7, 10'h8), 0, 0, 0, "chk_k17");
        c = mk_cmd(4, 4, 4, 10'h9, 10'ha, 10'hb, 10'hc);
        cyc(1, c, 0, 0, 0, "chk_valid");
        for (int i = 0; i < 20 && !m_offer; i++) cyc(0, 64'h0, 0, 0, 0, "chk_wait");
        chk("chk_offered", bus.cu_cmd_data, c);
        drain("chk_drain");
        chk("chk_err_count", 64'(err_count), 64'h2);
        chk("chk_issued", 64'(cmds_issued), 64'(base + 16'd1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
